// File: rtl/acc_cpu_core_p_if.sv
// rtl/acc_cpu_core_p_if.sv - instruction-memory fetch handshake between core and program ROM
interface acc_cpu_core_p_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 5
);
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_valid;
    logic [DATA_W+3:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_data
    );
endinterface

// File: rtl/acc_cpu_core_p.sv
// rtl/acc_cpu_core_p.sv - parametrised accumulator CPU core with fetch handshake and output strobe
module acc_cpu_core_p #(
    parameter int DATA_W = 8,
    parameter int RF_AW  = 3,
    parameter int PC_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enter,
    input  logic [DATA_W-1:0] user_in,
    acc_cpu_core_p_if.master  imem,
    output logic [DATA_W-1:0] cpu_out,
    output logic              out_valid,
    output logic [PC_W-1:0]   pc_out,
    output logic [3:0]        opcode_out,
    output logic              waiting_input,
    output logic              done
);
    localparam int RF_N = 2 ** RF_AW;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_IN   = 4'h2;
    localparam logic [3:0] OP_LDR  = 4'h3;
    localparam logic [3:0] OP_STR  = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_ROT  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JP   = 4'hD;
    localparam logic [3:0] OP_OUT  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WAIT_IN, S_HALTED} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              carry_q, carry_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W+3:0] ir_q, ir_d;
    logic [DATA_W-1:0] cpu_out_q, cpu_out_d;
    logic              out_valid_q, out_valid_d;
    logic              enter_q;
    logic [DATA_W-1:0] rf_q [RF_N];
    logic              rf_we;

    logic [3:0]        opcode;
    logic [DATA_W-1:0] operand;
    logic [RF_AW-1:0]  reg_sel;
    logic [PC_W-1:0]   target;
    logic [DATA_W-1:0] rf_rd;
    logic              zero, positive;
    logic [DATA_W:0]   sum, diff;
    logic [RF_AW-1:0]  rot_k;
    logic [DATA_W-1:0] rot_res;

    assign opcode   = ir_q[DATA_W+3:DATA_W];
    assign operand  = ir_q[DATA_W-1:0];
    assign reg_sel  = operand[RF_AW-1:0];
    assign target   = operand[PC_W-1:0];
    assign rf_rd    = rf_q[reg_sel];
    assign zero     = (acc_q == '0);
    assign positive = !acc_q[DATA_W-1] && !zero;
    assign sum      = {1'b0, acc_q} + {1'b0, rf_rd};
    // Top bit of the widened difference is the borrow out of acc - rf.
    assign diff     = {1'b0, acc_q} - {1'b0, rf_rd};
    assign rot_k    = RF_AW'(int'(operand[RF_AW-1:0]) % DATA_W);
    assign rot_res  = operand[DATA_W-1]
                    ? ((acc_q >> rot_k) | (acc_q << (DATA_W - int'(rot_k))))
                    : ((acc_q << rot_k) | (acc_q >> (DATA_W - int'(rot_k))));

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        cpu_out_d   = cpu_out_q;
        out_valid_d = 1'b0;
        rf_we       = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (imem.imem_valid) begin
                    ir_d    = imem.imem_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_LDI:  acc_d = operand;
                    OP_IN:   state_d = S_WAIT_IN;
                    OP_LDR:  acc_d = rf_rd;
                    OP_STR:  rf_we = 1'b1;
                    OP_ADD:  {carry_d, acc_d} = sum;
                    OP_SUB:  {carry_d, acc_d} = diff;
                    OP_AND:  acc_d = acc_q & rf_rd;
                    OP_OR:   acc_d = acc_q | rf_rd;
                    OP_XOR:  acc_d = acc_q ^ rf_rd;
                    OP_ROT:  acc_d = rot_res;
                    OP_JMP:  pc_d = target;
                    OP_JZ:   if (zero) pc_d = target;
                    OP_JP:   if (positive) pc_d = target;
                    OP_OUT: begin
                        cpu_out_d   = acc_q;
                        out_valid_d = 1'b1;
                    end
                    OP_HALT: state_d = S_HALTED;
                    default: ;
                endcase
            end
            // Only a fresh rising edge of enter releases the wait.
            S_WAIT_IN: begin
                if (enter && !enter_q) begin
                    acc_d   = user_in;
                    state_d = S_FETCH;
                end
            end
            S_HALTED: ;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            pc_q        <= '0;
            ir_q        <= '0;
            cpu_out_q   <= '0;
            out_valid_q <= 1'b0;
            enter_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            cpu_out_q   <= cpu_out_d;
            out_valid_q <= out_valid_d;
            enter_q     <= enter;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < RF_N; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[reg_sel] <= acc_q;
        end
    end

    assign imem.imem_req  = (state_q == S_FETCH);
    assign imem.imem_addr = pc_q;
    assign cpu_out        = cpu_out_q;
    assign out_valid      = out_valid_q;
    assign pc_out         = pc_q;
    assign opcode_out     = opcode;
    assign waiting_input  = (state_q == S_WAIT_IN);
    assign done           = (state_q == S_HALTED);
endmodule

// File: tb/tb_acc_cpu_core_p.sv
// tb/tb_acc_cpu_core_p.sv - scoreboard bench for acc_cpu_core_p with an ISA-level reference model
module tb_acc_cpu_core_p;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enter = 1'b0;
    logic [7:0] user_in = 8'h00;
    logic [7:0] cpu_out;
    logic       out_valid;
    logic [4:0] pc_out;
    logic [3:0] opcode_out;
    logic       waiting_input;
    logic       done;

    acc_cpu_core_p_if #(.DATA_W(8), .PC_W(5)) ifc ();

    acc_cpu_core_p #(.DATA_W(8), .RF_AW(3), .PC_W(5)) dut (
        .clock        (clock),
        .reset        (reset),
        .enter        (enter),
        .user_in      (user_in),
        .imem         (ifc),
        .cpu_out      (cpu_out),
        .out_valid    (out_valid),
        .pc_out       (pc_out),
        .opcode_out   (opcode_out),
        .waiting_input(waiting_input),
        .done         (done)
    );

    always #5 clock = ~clock;

    logic [11:0] rom [32];
    assign ifc.imem_data = rom[ifc.imem_addr];

    int stall_pct = 0;
    bit hold_low  = 1'b0;
    always @(negedge clock)
        ifc.imem_valid = !hold_low && ($urandom_range(0, 99) >= stall_pct);

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int user_q[$];
    int mq[$];
    int uvals[8];
    int mfpc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Output monitor: every strobe must match the oldest expected value.
    always @(negedge clock) begin
        if (reset && out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_extra act=%0h exp=none", cpu_out);
            end else begin
                chk("cpu_out", cpu_out, exp_q.pop_front());
            end
        end
    end

    // Instruction-level interpreter; fills mq with OUT values and mfpc with the final pc.
    function automatic bit model_run();
        int acc = 0;
        int pc = 0;
        int ui = 0;
        int rfm[8];
        int op, opd, r, k;
        mq.delete();
        foreach (rfm[i]) rfm[i] = 0;
        for (int s = 0; s < 200; s++) begin
            op  = int'(rom[pc]) / 256;
            opd = int'(rom[pc]) % 256;
            pc  = (pc + 1) % 32;
            r   = rfm[opd % 8];
            case (op)
                1:  acc = opd;
                2:  begin
                        if (ui >= 8) return 1'b0;
                        acc = uvals[ui];
                        ui++;
                    end
                3:  acc = r;
                4:  rfm[opd % 8] = acc;
                5:  acc = (acc + r) % 256;
                6:  acc = (acc - r + 256) % 256;
                7:  acc = acc & r;
                8:  acc = acc | r;
                9:  acc = acc ^ r;
                10: begin
                        k = opd % 8;
                        if (opd >= 128) acc = ((acc >> k) | (acc << (8 - k))) % 256;
                        else            acc = ((acc << k) | (acc >> (8 - k))) % 256;
                    end
                11: pc = opd % 32;
                12: if (acc == 0) pc = opd % 32;
                13: if (acc != 0 && acc < 128) pc = opd % 32;
                14: begin
                        mq.push_back(acc);
                        if (mq.size() > 40) return 1'b0;
                    end
                15: begin
                        mfpc = pc;
                        return 1'b1;
                    end
                default: ;
            endcase
        end
        return 1'b0;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        enter = 1'b0;
        @(posedge clock);
        @(posedge clock);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic run_until_done(input int budget, input int exp_pc);
        int cyc = 0;
        while (!done && cyc < budget) begin
            if (waiting_input && user_q.size() > 0) begin
                enter = 1'b0;
                @(negedge clock);
                user_in = 8'(user_q.pop_front());
                enter = 1'b1;
                @(negedge clock);
                enter = 1'b0;
                cyc += 2;
            end else begin
                @(negedge clock);
                cyc++;
            end
        end
        chk("done", done, 1);
        chk("final_pc", pc_out, exp_pc);
        chk("waiting_at_halt", waiting_input, 0);
        chk("outs_left", exp_q.size(), 0);
    endtask

    task automatic wait_waiting(input int budget);
        int cyc = 0;
        while (!waiting_input && cyc < budget) begin
            @(negedge clock);
            cyc++;
        end
        chk("reach_wait_in", waiting_input, 1);
    endtask

    task automatic load_basic();
        foreach (rom[i]) rom[i] = 12'hF00;
        rom[0] = 12'h105;
        rom[1] = 12'hE00;
        rom[2] = 12'hF00;
    endtask

    initial begin
        int tries;
        // Basic fetch timing with memory always ready
        load_basic();
        do_reset();
        chk("rst_imem_req", ifc.imem_req, 1);
        chk("rst_done", done, 0);
        chk("rst_waiting", waiting_input, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_opcode", opcode_out, 0);
        chk("rst_cpu_out", cpu_out, 0);
        chk("rst_out_valid", out_valid, 0);
        exp_q.push_back(8'h05);
        repeat (5) @(negedge clock);
        chk("done_cycle5", done, 0);
        @(negedge clock);
        chk("done_cycle6", done, 1);
        chk("basic_pc", pc_out, 3);
        chk("basic_opcode", opcode_out, 4'hF);
        chk("basic_outs_left", exp_q.size(), 0);

        // Stalled first fetch
        hold_low = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            chk("stall_req", ifc.imem_req, 1);
            chk("stall_pc", pc_out, 0);
            chk("stall_addr", ifc.imem_addr, 0);
            chk("stall_ir", opcode_out, 0);
            @(negedge clock);
        end
        hold_low = 1'b0;
        exp_q.push_back(8'h05);
        run_until_done(40, 3);

        // Arithmetic with carry and borrow
        foreach (rom[i]) rom[i] = 12'hF00;
        rom[0] = 12'h1F0; rom[1] = 12'h401; rom[2] = 12'h120; rom[3] = 12'h501;
        rom[4] = 12'hE00; rom[5] = 12'h601; rom[6] = 12'hE00; rom[7] = 12'hF00;
        do_reset();
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h20);
        run_until_done(60, 8);

        // Rotates, including amount zero
        foreach (rom[i]) rom[i] = 12'hF00;
        rom[0] = 12'h181; rom[1] = 12'hA01; rom[2] = 12'hE00; rom[3] = 12'hA81;
        rom[4] = 12'hE00; rom[5] = 12'hA80; rom[6] = 12'hE00; rom[7] = 12'hF00;
        do_reset();
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h81);
        run_until_done(60, 8);

        // Branches and pc wrap through address 31
        foreach (rom[i]) rom[i] = 12'hF00;
        rom[0] = 12'h302; rom[1] = 12'hC03; rom[2] = 12'hF00; rom[3] = 12'h180;
        rom[4] = 12'hD02; rom[5] = 12'hE00; rom[6] = 12'h402; rom[7] = 12'hB1F;
        rom[31] = 12'h000;
        do_reset();
        exp_q.push_back(8'h80);
        run_until_done(80, 3);

        // Input wait: enter already high must not release it
        foreach (rom[i]) rom[i] = 12'hF00;
        rom[0] = 12'h200; rom[1] = 12'hE00; rom[2] = 12'hF00;
        do_reset();
        enter = 1'b1;
        user_in = 8'h55;
        wait_waiting(20);
        repeat (3) @(negedge clock);
        chk("held_enter_wait", waiting_input, 1);
        enter = 1'b0;
        @(negedge clock);
        user_in = 8'h3C;
        enter = 1'b1;
        @(negedge clock);
        enter = 1'b0;
        exp_q.push_back(8'h3C);
        run_until_done(40, 3);

        // Reset pulsed during WAIT_IN, then OUT proves acc was cleared
        foreach (rom[i]) rom[i] = 12'hF00;
        rom[0] = 12'h177; rom[1] = 12'h200; rom[2] = 12'hE00; rom[3] = 12'hF00;
        do_reset();
        wait_waiting(20);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        rom[0] = 12'hE00; rom[1] = 12'hF00;
        chk("midrst_pc", pc_out, 0);
        chk("midrst_waiting", waiting_input, 0);
        chk("midrst_req", ifc.imem_req, 1);
        chk("midrst_done", done, 0);
        exp_q.push_back(8'h00);
        run_until_done(40, 2);

        // Random programs with random memory stalls
        for (int p = 0; p < 12; p++) begin
            tries = 0;
            do begin
                for (int i = 0; i < 32; i++) begin
                    int op;
                    op = $urandom_range(0, 15);
                    if ($urandom_range(0, 11) == 0) op = 15;
                    rom[i] = 12'(op * 256 + $urandom_range(0, 255));
                end
                foreach (uvals[i]) uvals[i] = $urandom_range(0, 255);
                tries++;
            end while (!model_run() && tries < 2000);
            if (tries >= 2000) continue;
            stall_pct = $urandom_range(0, 50);
            do_reset();
            user_q.delete();
            foreach (uvals[i]) user_q.push_back(uvals[i]);
            foreach (mq[i]) exp_q.push_back(mq[i]);
            run_until_done(3000, mfpc);
        end
        stall_pct = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
